m_wb_leds: RTL and testbench

M_WB_LEDS -- requirements
Module: m_wb_leds

---
 rtl/m_wb_leds_pkg.sv | 27 ++
 rtl/m_wb_leds_if.sv | 21 ++
 rtl/m_wb_leds_chan.sv | 28 ++
 rtl/m_wb_leds.sv | 138 +++++++++++++
 tb/tb_m_wb_leds.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/m_wb_leds_pkg.sv
// Shared constants for the Wishbone LED controller: register word
// addresses and the per-channel MODE encodings.
package m_wb_leds_pkg;

   // Register word addresses (ADR_I is bus ADR_O[5:2])
   localparam logic [3:0] ADR_OUT   = 4'd0;
   localparam logic [3:0] ADR_MODE  = 4'd1;
   localparam logic [3:0] ADR_PRESC = 4'd2;
   localparam logic [3:0] ADR_STAT  = 4'd3;
   localparam logic [3:0] ADR_DUTY  = 4'd8;

   // Per-channel drive mode, 2 bits per channel in MODE
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_PWM    = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_INV    = 2'b11
   } mode_e;

   // Expand the four byte-lane enables into a 32-bit bit mask
   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
      return m;
   endfunction

endpackage

// File: rtl/m_wb_leds_if.sv
// Wishbone classic slave bus bundle for the LED controller.
interface m_wb_leds_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [3:0]  ADR_I;
   logic [3:0]  SEL_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      output DAT_O, ACK_O
   );

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      input  DAT_O, ACK_O
   );
endinterface

// File: rtl/m_wb_leds_chan.sv
// One LED channel: combinational next-state of the LED pin from the
// channel's mode, level, duty and the shared counters.
module m_wb_leds_chan
   import m_wb_leds_pkg::*;
#(
   parameter int PWMBITS = 8
) (
   input  logic [1:0]         mode,
   input  logic               out,
   input  logic [PWMBITS-1:0] duty,
   input  logic [PWMBITS-1:0] pwmcnt,
   input  logic               blink,
   output logic               led_nxt
);

   // Select the drive function for this channel
   always_comb begin
      led_nxt = 1'b0;
      case (mode)
         MODE_STATIC: led_nxt = out;
         MODE_PWM:    led_nxt = out & (pwmcnt < duty);
         MODE_BLINK:  led_nxt = out & blink;
         MODE_INV:    led_nxt = ~out;
         default:     led_nxt = 1'b0;
      endcase
   end

endmodule

// File: rtl/m_wb_leds.sv
// Wishbone LED controller: register file, prescaler, PWM/blink counters
// and registered LED outputs. Per-channel drive logic lives in
// m_wb_leds_chan.
module m_wb_leds
   import m_wb_leds_pkg::*;
#(
   parameter int          NCH       = 4,
   parameter int          PWMBITS   = 8,
   parameter int          PRESCW    = 16,
   parameter int unsigned PRESC_RST = 0
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   m_wb_leds_if.slave       wb,
   output logic [NCH-1:0]   LED_O
);

   localparam logic [PRESCW-1:0] PRESC_INIT = PRESCW'(PRESC_RST);

   logic                            access, wr, rd;
   logic [31:0]                     wmask, rdata;

   logic [NCH-1:0]                  out_r;
   logic [2*NCH-1:0]                mode_r;
   logic [PRESCW-1:0]               presc_r, pcnt_r, presc_wr;
   logic [NCH-1:0][PWMBITS-1:0]     duty_r;
   logic [PWMBITS-1:0]              pwmcnt;
   logic [3:0]                      blinkcnt;
   logic                            tick, wrap;
   logic [NCH-1:0]                  led_nxt;

   // High data bits and lane-mask bits beyond the widest register are
   // intentionally ignored.
   logic                            unused_bits;
   assign unused_bits = ^{wb.DAT_I, wmask};

   // No new access is taken while ACK_O is high, so each strobe gets
   // exactly one single-cycle acknowledge.
   assign access = wb.CYC_I & wb.STB_I & ~wb.ACK_O;
   assign wr     = access &  wb.WE_I;
   assign rd     = access & ~wb.WE_I;
   assign wmask  = lane_mask(wb.SEL_I);

   // PRESC write value is shared by the register and the counter reload
   assign presc_wr = (presc_r & ~wmask[PRESCW-1:0]) |
                     (wb.DAT_I[PRESCW-1:0] & wmask[PRESCW-1:0]);

   assign tick = (pcnt_r == '0);
   assign wrap = tick & (&pwmcnt);

   // Read multiplexer; unimplemented bits and addresses read 0
   always_comb begin
      rdata = '0;
      case (wb.ADR_I)
         ADR_OUT:   rdata[NCH-1:0]    = out_r;
         ADR_MODE:  rdata[2*NCH-1:0]  = mode_r;
         ADR_PRESC: rdata[PRESCW-1:0] = presc_r;
         ADR_STAT: begin
            rdata[19:16]        = blinkcnt;
            rdata[PWMBITS-1:0]  = pwmcnt;
         end
         default: begin
            for (int c = 0; c < NCH; c++)
               if (wb.ADR_I == ADR_DUTY + 4'(c)) rdata[PWMBITS-1:0] = duty_r[c];
         end
      endcase
   end

   // Bus response: registered acknowledge and read data
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         wb.ACK_O <= 1'b0;
         wb.DAT_O <= '0;
      end else begin
         wb.ACK_O <= access;
         if (rd) wb.DAT_O <= rdata;
      end
   end

   // Register writes, byte-lane masked, committed at the access edge
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         out_r   <= '0;
         mode_r  <= '0;
         presc_r <= PRESC_INIT;
         duty_r  <= '0;
      end else if (wr) begin
         if (wb.ADR_I == ADR_OUT)
            out_r <= (out_r & ~wmask[NCH-1:0]) | (wb.DAT_I[NCH-1:0] & wmask[NCH-1:0]);
         if (wb.ADR_I == ADR_MODE)
            mode_r <= (mode_r & ~wmask[2*NCH-1:0]) | (wb.DAT_I[2*NCH-1:0] & wmask[2*NCH-1:0]);
         if (wb.ADR_I == ADR_PRESC)
            presc_r <= presc_wr;
         for (int c = 0; c < NCH; c++)
            if (wb.ADR_I == ADR_DUTY + 4'(c))
               duty_r[c] <= (duty_r[c] & ~wmask[PWMBITS-1:0]) |
                            (wb.DAT_I[PWMBITS-1:0] & wmask[PWMBITS-1:0]);
      end
   end

   // Prescaler down-counter; a PRESC write restarts it with the new value
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I)                        pcnt_r <= PRESC_INIT;
      else if (wr && wb.ADR_I == ADR_PRESC) pcnt_r <= presc_wr;
      else if (tick)                      pcnt_r <= presc_r;
      else                                pcnt_r <= pcnt_r - 1'b1;
   end

   // PWM phase counter and blink counter, advanced by the prescaler tick
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         pwmcnt   <= '0;
         blinkcnt <= '0;
      end else begin
         if (tick) pwmcnt   <= pwmcnt + 1'b1;
         if (wrap) blinkcnt <= blinkcnt + 1'b1;
      end
   end

   // Per-channel drive logic
   for (genvar c = 0; c < NCH; c++) begin : g_chan
      m_wb_leds_chan #(.PWMBITS(PWMBITS)) u_chan (
         .mode    (mode_r[2*c +: 2]),
         .out     (out_r[c]),
         .duty    (duty_r[c]),
         .pwmcnt  (pwmcnt),
         .blink   (blinkcnt[3]),
         .led_nxt (led_nxt[c])
      );
   end

   // Registered LED pins
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) LED_O <= '0;
      else         LED_O <= led_nxt;
   end

endmodule

// File: tb/tb_m_wb_leds.sv
// Directed bench for m_wb_leds: bus transactions push expected responses
// into a scoreboard queue that a monitor drains on every ACK_O.
module tb_m_wb_leds;
   import m_wb_leds_pkg::*;

   localparam int NCH = 4, PWMBITS = 8, PRESCW = 16, PRESC_RST = 5;

   logic           CLK_I  = 1'b0;
   logic           RSTN_I = 1'b0;
   logic [NCH-1:0] LED_O;

   m_wb_leds_if wb ();

   m_wb_leds #(.NCH(NCH), .PWMBITS(PWMBITS), .PRESCW(PRESCW), .PRESC_RST(PRESC_RST)) dut (
      .CLK_I  (CLK_I),
      .RSTN_I (RSTN_I),
      .wb     (wb),
      .LED_O  (LED_O)
   );

   always #5 CLK_I = ~CLK_I;

   typedef struct {
      logic        chk;
      logic [31:0] d;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0, failures = 0, cyc_cnt = 0, last_ack_cyc = 0;
   logic [31:0] last_rd = '0;

   always @(posedge CLK_I) cyc_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every acknowledge must match the oldest expected response
   always @(negedge CLK_I) begin
      exp_t e;
      if (wb.ACK_O === 1'b1) begin
         last_rd      = wb.DAT_O;
         last_ack_cyc = cyc_cnt;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ACK_O=1 with no access pending");
         end else begin
            e = sb.pop_front();
            if (e.chk) check(e.name, wb.DAT_O, e.d);
         end
      end
   end

   task automatic bus(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic chk, input logic [31:0] exp,
                      input string name);
      exp_t e;
      int   n;
      e.chk = chk; e.d = exp; e.name = name;
      sb.push_back(e);
      @(posedge CLK_I); #1;
      wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we;
      wb.ADR_I = adr;  wb.SEL_I = sel;  wb.DAT_I = dat;
      n = 0;
      do begin
         @(posedge CLK_I); #1;
         n++;
      end while (wb.ACK_O !== 1'b1 && n < 8);
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
      check({name, "_ack_lat"}, 32'(n), 32'd1);
      @(posedge CLK_I); #1;
      check({name, "_ack_low"}, 32'(wb.ACK_O), 32'd0);
   endtask

   task automatic wr(input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                     input string name);
      bus(1'b1, adr, sel, dat, 1'b0, 32'd0, name);
   endtask

   task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
      bus(1'b0, adr, 4'hF, 32'd0, 1'b1, exp, name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, c0, c1, c2, ca, cb;
      logic        prev;
      logic [31:0] s1, s2;
      logic [11:0] t1, t2;

      wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
      wb.ADR_I = '0;   wb.SEL_I = '0;   wb.DAT_I = '0;

      repeat (3) @(posedge CLK_I);
      #1;
      check("rst_ack", 32'(wb.ACK_O), 32'd0);
      check("rst_dat", wb.DAT_O, 32'd0);
      check("rst_led", 32'(LED_O), 32'd0);
      RSTN_I = 1'b1;

      // Reset value of PRESC
      rd(ADR_PRESC, 32'd5, "presc_rst");

      // Static and inverted modes
      wr(ADR_OUT, 4'hF, 32'hA, "out_wr");
      check("led_static", 32'(LED_O), 32'hA);
      rd(ADR_OUT, 32'hA, "out_rd");
      wr(ADR_MODE, 4'hF, 32'hC0, "mode_inv");
      check("led_inv_on", 32'(LED_O), 32'h2);
      wr(ADR_OUT, 4'hF, 32'h3, "out_wr2");
      check("led_inv_off", 32'(LED_O), 32'hB);

      // Byte-lane masking
      wr(ADR_PRESC, 4'hF, 32'h1234, "presc_full");
      wr(ADR_PRESC, 4'b0010, 32'hABCD, "presc_lane1");
      rd(ADR_PRESC, 32'hAB34, "presc_lane_rd");

      // Unimplemented addresses and empty lane enables
      wr(4'd15, 4'hF, 32'hFFFF_FFFF, "adr15_wr");
      rd(4'd15, 32'd0, "adr15_rd");
      rd(4'd4, 32'd0, "adr4_rd");
      wr(4'd9, 4'b0000, 32'hFF, "duty1_sel0");
      rd(4'd9, 32'd0, "duty1_rd");
      rd(ADR_MODE, 32'hC0, "mode_kept");

      // PWM and blink setup
      wr(ADR_PRESC, 4'hF, 32'd0, "presc_zero");
      wr(4'd8, 4'hF, 32'd64, "duty0_wr");
      wr(4'd10, 4'hF, 32'd255, "duty2_wr");
      wr(ADR_OUT, 4'hF, 32'hF, "out_all");
      wr(ADR_MODE, 4'hF, 32'h95, "mode_pwm");
      rd(ADR_MODE, 32'h95, "mode_rd");
      rd(4'd8, 32'd64, "duty0_rd");
      rd(4'd10, 32'd255, "duty2_rd");

      // PWM duty over one full period
      repeat (2) @(posedge CLK_I);
      c0 = 0; c1 = 0; c2 = 0;
      repeat (256) begin
         @(negedge CLK_I);
         c0 += int'(LED_O[0]);
         c1 += int'(LED_O[1]);
         c2 += int'(LED_O[2]);
      end
      check("pwm_duty64", 32'(c0), 32'd64);
      check("pwm_duty0", 32'(c1), 32'd0);
      check("pwm_duty255", 32'(c2), 32'd255);

      // STAT advances one count per tick, carrying into blinkcnt
      bus(1'b0, ADR_STAT, 4'hF, 32'd0, 1'b0, 32'd0, "stat_rd1");
      s1 = last_rd; ca = last_ack_cyc;
      repeat (300) @(posedge CLK_I);
      bus(1'b0, ADR_STAT, 4'hF, 32'd0, 1'b0, 32'd0, "stat_rd2");
      s2 = last_rd; cb = last_ack_cyc;
      t1 = {s1[19:16], s1[7:0]};
      t2 = {s2[19:16], s2[7:0]};
      check("stat_count", 32'(t2), 32'(t1 + 12'(cb - ca)));
      check("stat_zero_bits", s2 & 32'hFFF0_FF00, 32'd0);
      check("stat_blink_moved", 32'(s2[19:16] != s1[19:16]), 32'd1);

      // Blink period: LED_O[3] toggles every 8*256 cycles
      @(negedge CLK_I);
      prev = LED_O[3];
      n = 0;
      while (LED_O[3] == prev && n < 4200) begin
         @(negedge CLK_I);
         n++;
      end
      check("blink_first_edge", 32'(LED_O[3] != prev), 32'd1);
      prev = LED_O[3];
      n = 0;
      while (LED_O[3] == prev && n < 4200) begin
         @(negedge CLK_I);
         n++;
      end
      check("blink_period", 32'(n), 32'd2048);

      // Reset during an access: no acknowledge, no write
      @(posedge CLK_I); #1;
      wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b1;
      wb.ADR_I = ADR_PRESC; wb.SEL_I = 4'hF; wb.DAT_I = 32'h77;
      #2 RSTN_I = 1'b0;
      @(posedge CLK_I); #1;
      check("rst_mid_ack", 32'(wb.ACK_O), 32'd0);
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
      @(posedge CLK_I); #1;
      RSTN_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      #1;
      check("rst_mid_ack_after", 32'(wb.ACK_O), 32'd0);
      check("rst_mid_led", 32'(LED_O), 32'd0);
      rd(ADR_PRESC, 32'd5, "presc_after_rst");
      rd(ADR_OUT, 32'd0, "out_after_rst");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
